// File: rtl/occupancy_pkg.sv
// Shared types for the occupancy arbiter: FSM states and counter op codes.
package occupancy_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StLoad,
    StWait
  } state_e;

  typedef enum logic [1:0] {
    OpNone,
    OpInc,
    OpDec,
    OpLoad
  } op_e;

  // Index width for a request vector of w bits (at least one bit).
  function automatic int unsigned idx_width(int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import occupancy_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned IW = idx_width(W)
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  // Scan W positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < W; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= W) idx = idx - W;
      if (!valid && req[idx[IW-1:0]]) begin
        valid = 1'b1;
        grant = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/occupancy_arbiter.sv
// Serialises entry/exit/preset requests onto a shared up/down occupancy counter.
// One counter operation per IDLE -> ISSUE/LOAD -> WAIT transaction.
module occupancy_arbiter
  import occupancy_pkg::*;
#(
  parameter int unsigned n   = 4,
  parameter int unsigned MAX = 9,
  parameter int unsigned NE  = 2,
  parameter int unsigned NX  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NE-1:0] ent_req,
  input  logic [NX-1:0] ext_req,
  output logic [NE-1:0] ent_ack,
  output logic [NE-1:0] ent_nack,
  output logic [NX-1:0] ext_ack,
  output logic [NX-1:0] ext_nack,
  input  logic          cfg_load,
  input  logic [n-1:0]  cfg_value,
  output logic          cfg_ack,
  input  logic [n-1:0]  count_in,
  output logic          cnt_en,
  output logic          cnt_inc,
  output logic          cnt_dec,
  output logic          cnt_load,
  output logic [n-1:0]  cnt_loadin,
  output logic          full,
  output logic          empty
);

  localparam int unsigned W      = NE + NX;
  localparam int unsigned IW     = idx_width(W);
  localparam logic [n-1:0] MaxVal = n'(MAX);

  state_e        state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] ptr_q;
  logic [n-1:0]  load_q;

  logic [IW-1:0] arb_grant;
  logic          arb_valid;
  logic [n-1:0]  cfg_clamped;
  logic [W-1:0]  grant_oh;
  logic          is_ent;
  op_e           op;

  assign full        = (count_in >= MaxVal);
  assign empty       = (count_in == '0);
  assign cfg_clamped = (cfg_value > MaxVal) ? MaxVal : cfg_value;

  // Exit requests occupy the upper half of the combined vector.
  rr_arbiter #(
    .W  (W),
    .IW (IW)
  ) u_rr (
    .req   ({ext_req, ent_req}),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Transaction FSM: captures grant/preset in IDLE, advances rr pointer on ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      load_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_load) begin
            load_q  <= cfg_clamped;
            state_q <= StLoad;
          end else if (arb_valid) begin
            grant_q <= arb_grant;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          ptr_q   <= (32'(grant_q) == W - 1) ? '0 : grant_q + IW'(1);
          state_q <= StWait;
        end
        StLoad:  state_q <= StWait;
        StWait:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decode the counter op for this cycle; full/empty are judged on the live count.
  always_comb begin
    grant_oh = W'(1) << grant_q;
    is_ent   = (32'(grant_q) < NE);
    op       = OpNone;
    if (state_q == StIssue) begin
      if (is_ent) op = full ? OpNone : OpInc;
      else        op = empty ? OpNone : OpDec;
    end else if (state_q == StLoad) begin
      op = OpLoad;
    end
  end

  // Drive pulses and counter controls from the decoded op.
  always_comb begin
    ent_ack    = '0;
    ent_nack   = '0;
    ext_ack    = '0;
    ext_nack   = '0;
    if (state_q == StIssue) begin
      if (is_ent) begin
        if (op == OpInc) ent_ack  = grant_oh[NE-1:0];
        else             ent_nack = grant_oh[NE-1:0];
      end else begin
        if (op == OpDec) ext_ack  = grant_oh[W-1:NE];
        else             ext_nack = grant_oh[W-1:NE];
      end
    end
    cnt_inc    = (op == OpInc);
    cnt_dec    = (op == OpDec);
    cnt_en     = cnt_inc | cnt_dec;
    cnt_load   = (op == OpLoad);
    cfg_ack    = cnt_load;
    cnt_loadin = cnt_load ? load_q : '0;
  end

endmodule
